// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//  Shared types and helpers for the LED position sequencer.
//  - mode_t   : run mode of the controller (MANUAL, AUTO_R, AUTO_L, HOLD)
//  - LED_NUM  : width of the raw one-hot decode; users cast down to their LED count
//  - pos2led  : position -> one-hot LED pattern (pos 0 and out-of-range -> all off)
//  - next_mode: key_mode rotation MANUAL -> AUTO_R -> AUTO_L -> HOLD -> MANUAL
package led_seq_pkg;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      AUTO_R = 2'd1,
      AUTO_L = 2'd2,
      HOLD   = 2'd3
   } mode_t;

   // A 4-bit position can address at most 15 LEDs, so 16 bits covers every case.
   localparam int LED_NUM = 16;

   // Position k lights led[k-1] only; 0 and anything above pmax stay dark.
   function automatic logic [LED_NUM-1:0] pos2led(input logic [3:0] p,
                                                  input logic [3:0] pmax);
      pos2led = '0;
      if ((p != 4'd0) && (p <= pmax)) begin
         pos2led[p - 4'd1] = 1'b1;
      end
   endfunction

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MANUAL:  next_mode = AUTO_R;
         AUTO_R:  next_mode = AUTO_L;
         AUTO_L:  next_mode = HOLD;
         default: next_mode = MANUAL;
      endcase
   endfunction

endpackage

// File: rtl/led_seq_if.sv
// led_seq_if
//  Bundles the debounced key flags going into the sequencer and the display
//  outputs coming back out.
//  Signals:
//   key_right, key_left, key_mode : 1-cycle debounced key flags
//   pos   : current position (4 bits)
//   led   : one-hot LED pattern (LED_W bits)
//   mode  : run mode (0 MANUAL, 1 AUTO_R, 2 AUTO_L, 3 HOLD)
//   step  : 1-cycle pulse after every position change
//  Modports:
//   master : key source / observer (drives flags, reads display)
//   slave  : the controller (reads flags, drives display)
interface led_seq_if #(
   parameter int LED_W = 8
);
   logic             key_right;
   logic             key_left;
   logic             key_mode;
   logic [3:0]       pos;
   logic [LED_W-1:0] led;
   logic [1:0]       mode;
   logic             step;

   modport master (
      output key_right, key_left, key_mode,
      input  pos, led, mode, step
   );

   modport slave (
      input  key_right, key_left, key_mode,
      output pos, led, mode, step
   );
endinterface

// File: rtl/led_seq_tick.sv
// led_seq_tick
//  Auto-run timebase. Counts 0..TICK_DIV-1 while enabled and raises tick in the
//  cycle the count sits at TICK_DIV-1, so the consumer steps on the wrap edge.
//  Ports:
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   en   in  count enable (high only in the auto-run modes)
//   clr  in  synchronous clear, restarts the period from 0
//   tick out one-cycle step request
module led_seq_tick #(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Counter is held at 0 whenever disabled or cleared, so a freshly entered
   // auto mode always waits a full TICK_DIV period before its first step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || !en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // clr is deliberately left out here: clr depends on the next mode, which in
   // bounce builds depends on tick, and including it would close a comb loop.
   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
//  Controller for the 8-LED position display. Arbitrates position steps between
//  the manual key flags and the auto-run timer, owns the position register and
//  the registered one-hot LED decode.
//  Ports:
//   clk  in  system clock, all logic on posedge
//   rst  in  asynchronous reset, active-high
//   bus  led_seq_if.slave: key_right/key_left/key_mode in; pos/led/mode/step out
//  Build option:
//   LED_SEQ_BOUNCE_EN : when defined, the auto modes ping-pong at the ends of
//                       the range instead of wrapping (MANUAL always wraps).
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int LED_W    = 8,
   parameter int POS_MAX  = 8,
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input logic   clk,
   input logic   rst,
   led_seq_if.slave bus
);

   localparam logic [3:0] POS_TOP = 4'(POS_MAX);

   mode_t            mode_q;
   mode_t            mode_next;
   logic [3:0]       pos_q;
   logic [3:0]       pos_next;
   logic [3:0]       pos_inc;
   logic [3:0]       pos_dec;
   logic [LED_W-1:0] led_q;
   logic             step_q;
   logic             tick;
   logic             tick_en;
   logic             tick_clr;

   // Timer runs only in the auto modes and restarts on every mode change,
   // direction changes included.
   assign tick_en  = (mode_q == AUTO_R) || (mode_q == AUTO_L);
   assign tick_clr = (mode_next != mode_q);

   led_seq_tick #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick)
   );

   // Wrapping neighbours of the current position.
   assign pos_inc = (pos_q == POS_TOP) ? 4'd0    : pos_q + 4'd1;
   assign pos_dec = (pos_q == 4'd0)    ? POS_TOP : pos_q - 4'd1;

   // Next-state and arbitration: key_mode beats everything; below that only
   // one position step can happen per cycle. Direction keys in the auto modes
   // only flip direction and never move pos themselves.
   always_comb begin
      mode_next = mode_q;
      pos_next  = pos_q;
      if (bus.key_mode) begin
         mode_next = next_mode(mode_q);
      end else begin
         case (mode_q)
            MANUAL: begin
               if (bus.key_right) begin
                  pos_next = pos_inc;
               end else if (bus.key_left) begin
                  pos_next = pos_dec;
               end
            end
            AUTO_R: begin
               if (bus.key_left) begin
                  mode_next = AUTO_L;
               end else if (tick) begin
`ifdef LED_SEQ_BOUNCE_EN
                  if (pos_q == POS_TOP) begin
                     pos_next  = POS_TOP - 4'd1;
                     mode_next = AUTO_L;
                  end else begin
                     pos_next = pos_inc;
                  end
`else
                  pos_next = pos_inc;
`endif
               end
            end
            AUTO_L: begin
               if (bus.key_right) begin
                  mode_next = AUTO_R;
               end else if (tick) begin
`ifdef LED_SEQ_BOUNCE_EN
                  if (pos_q == 4'd0) begin
                     pos_next  = 4'd1;
                     mode_next = AUTO_R;
                  end else begin
                     pos_next = pos_dec;
                  end
`else
                  pos_next = pos_dec;
`endif
               end
            end
            default: begin
               // HOLD: position frozen, only key_mode (handled above) acts.
            end
         endcase
      end
   end

   // State, position and display registers. led is decoded from pos_next so
   // it lands on the same edge as pos and never lags it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MANUAL;
         pos_q  <= 4'd0;
         led_q  <= '0;
         step_q <= 1'b0;
      end else begin
         mode_q <= mode_next;
         pos_q  <= pos_next;
         led_q  <= LED_W'(pos2led(pos_next, POS_TOP));
         step_q <= (pos_next != pos_q);
      end
   end

   assign bus.pos  = pos_q;
   assign bus.led  = led_q;
   assign bus.mode = mode_q;
   assign bus.step = step_q;

endmodule
